// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 key receiver.
package ps2_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;

  localparam logic [1:0] ERR_PARITY  = 2'b01;
  localparam logic [1:0] ERR_STOP    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } key_evt_t;

endpackage

// File: rtl/ps2_key_fifo.sv
// First-word fall-through key-event FIFO with occupancy count.
module ps2_key_fifo
  import ps2_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  key_evt_t      din,
  input  logic          pop,
  output key_evt_t      dout,
  output logic          valid,
  output logic          ovf,
  output logic [CW-1:0] count
);

  key_evt_t      mem_q [DEPTH];
  key_evt_t      mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  // A pop frees the slot a same-cycle push needs, so full+push+pop is not an overflow.
  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != CW'(DEPTH)) || do_pop);
  assign ovf     = push && !do_push;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign valid = (count_q != '0);
  assign dout  = valid ? mem_q[rd_ptr_q] : '0;
  assign count = count_q;

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: sync, clock glitch filter, frame FSM with timeout,
// E0/F0 prefix decode and a flow-controlled key-event FIFO.
module ps2_key_receiver
  import ps2_pkg::*;
#(
  parameter  int SYNC_STAGES    = 3,
  parameter  int FILTER_LEN     = 8,
  parameter  int TIMEOUT_CYCLES = 50000,
  parameter  int FIFO_DEPTH     = 8,
  localparam int CW             = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ps2_clk,
  input  logic          ps2_data,
  output logic          key_valid,
  input  logic          key_ready,
  output logic [7:0]    key_code,
  output logic          key_ext,
  output logic          key_release,
  output logic          frame_err,
  output logic [1:0]    err_code,
  output logic          overflow,
  output logic [CW-1:0] fifo_count
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sclk_q, sclk_d, sdat_q, sdat_d;
  logic [FW-1:0]          fcnt_q, fcnt_d;
  logic                   filt_q, filt_d, filt_prev_q;
  logic                   clk_s, dat_s, fall;
  ps2_state_t             state_q, state_d;
  logic [2:0]             idx_q, idx_d;
  logic [7:0]             shreg_q, shreg_d, rx_byte_q, rx_byte_d;
  logic                   par_ok_q, par_ok_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic                   good_q, good_d, err_q, err_d;
  logic [1:0]             err_code_q, err_code_d;
  logic                   ext_pend_q, ext_pend_d, rel_pend_q, rel_pend_d;
  logic                   push;
  key_evt_t               push_evt, head_evt;

  assign clk_s = sclk_q[SYNC_STAGES-1];
  assign dat_s = sdat_q[SYNC_STAGES-1];
  assign fall  = filt_prev_q & ~filt_q;

  // Filtered level flips only after FILTER_LEN consecutive disagreeing samples.
  always_comb begin
    sclk_d = {sclk_q[SYNC_STAGES-2:0], ps2_clk};
    sdat_d = {sdat_q[SYNC_STAGES-2:0], ps2_data};
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_s != filt_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1)) filt_d = clk_s;
      else                               fcnt_d = fcnt_q + FW'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    shreg_d    = shreg_q;
    par_ok_d   = par_ok_q;
    rx_byte_d  = rx_byte_q;
    good_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    tmo_d      = (state_q == IDLE || fall) ? '0 : tmo_q + TW'(1);
    if (fall) begin
      case (state_q)
        IDLE: if (!dat_s) begin
          state_d = DATA;
          idx_d   = 3'd0;
        end
        DATA: begin
          shreg_d = {dat_s, shreg_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_ok_d = ^{shreg_q, dat_s};
          state_d  = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (par_ok_q && dat_s) begin
            good_d    = 1'b1;
            rx_byte_d = shreg_q;
          end else begin
            err_d      = 1'b1;
            err_code_d = par_ok_q ? ERR_STOP : ERR_PARITY;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d    = IDLE;
      err_d      = 1'b1;
      err_code_d = ERR_TIMEOUT;
      tmo_d      = '0;
    end
  end

  // Prefix bytes only arm the pending flags; everything else becomes an event.
  assign push     = good_q && (rx_byte_q != PS2_EXT) && (rx_byte_q != PS2_BRK);
  assign push_evt = '{ext: ext_pend_q, rel: rel_pend_q, code: rx_byte_q};

  always_comb begin
    ext_pend_d = ext_pend_q;
    rel_pend_d = rel_pend_q;
    if (err_q || push) begin
      ext_pend_d = 1'b0;
      rel_pend_d = 1'b0;
    end else if (good_q) begin
      if (rx_byte_q == PS2_EXT) ext_pend_d = 1'b1;
      if (rx_byte_q == PS2_BRK) rel_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_q      <= '1;
      sdat_q      <= '1;
      fcnt_q      <= '0;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      state_q     <= IDLE;
      idx_q       <= '0;
      shreg_q     <= '0;
      par_ok_q    <= 1'b0;
      rx_byte_q   <= '0;
      tmo_q       <= '0;
      good_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
      ext_pend_q  <= 1'b0;
      rel_pend_q  <= 1'b0;
    end else begin
      sclk_q      <= sclk_d;
      sdat_q      <= sdat_d;
      fcnt_q      <= fcnt_d;
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      state_q     <= state_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      par_ok_q    <= par_ok_d;
      rx_byte_q   <= rx_byte_d;
      tmo_q       <= tmo_d;
      good_q      <= good_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      ext_pend_q  <= ext_pend_d;
      rel_pend_q  <= rel_pend_d;
    end
  end

  ps2_key_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_evt),
    .pop   (key_ready),
    .dout  (head_evt),
    .valid (key_valid),
    .ovf   (overflow),
    .count (fifo_count)
  );

  assign key_code    = head_evt.code;
  assign key_ext     = head_evt.ext;
  assign key_release = head_evt.rel;
  assign frame_err   = err_q;
  assign err_code    = err_code_q;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Directed bench: PS/2 frames driven bit by bit, key events popped and compared to hand values.
module tb_ps2_key_receiver;

  localparam int HALF = 20;   // ps2_clk half period in clk cycles (scaled down for sim time)
  localparam int TMO  = 500;

  logic       clk = 1'b0;
  logic       rst, ps2_clk, ps2_data, key_ready;
  logic       key_valid, key_ext, key_release, frame_err, overflow;
  logic [7:0] key_code;
  logic [1:0] err_code;
  logic [3:0] fifo_count;

  int         vectors = 0, miscompares = 0;
  int         err_cnt = 0, ovf_cnt = 0;
  logic [1:0] last_err = 2'b00;

  ps2_key_receiver #(
    .SYNC_STAGES(3), .FILTER_LEN(8), .TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_valid(key_valid), .key_ready(key_ready), .key_code(key_code),
    .key_ext(key_ext), .key_release(key_release), .frame_err(frame_err),
    .err_code(err_code), .overflow(overflow), .fifo_count(fifo_count)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) begin
      err_cnt  = err_cnt + 1;
      last_err = err_code;
    end
    if (overflow) ovf_cnt = ovf_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic ps2_bit(input logic b, input bit glitch, input bit lat);
    repeat (HALF/2) @(negedge clk);
    ps2_data = b;
    if (glitch) begin
      ps2_clk = 1'b0;
      repeat (3) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (HALF/2 - 3) @(negedge clk);
    end else begin
      repeat (HALF/2) @(negedge clk);
    end
    ps2_clk = 1'b0;
    if (lat) begin
      // 3 sync + 8 filter edges to the fall pulse, then 2 more to key_valid
      repeat (12) @(posedge clk);
      #1 chk("lat_pre", 32'(key_valid), 32'd0);
      @(posedge clk);
      #1 chk("lat_valid", 32'(key_valid), 32'd1);
      repeat (HALF - 13) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit par_flip, input logic stop,
                            input int glitch_bit, input bit lat, input int nbits);
    logic [10:0] fr;
    fr = {stop, (~^b) ^ par_flip, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(fr[i], i == glitch_bit, lat && i == 10);
    repeat (HALF) @(negedge clk);
  endtask

  task automatic good(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b1, -1, 1'b0, 11);
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] code, input logic ext, input logic rel);
    chk(tag, 32'({key_valid, key_ext, key_release, key_code}), 32'({1'b1, ext, rel, code}));
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; key_ready = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset_outs", 32'({key_valid, key_code, key_ext, key_release, frame_err, err_code,
                           overflow, fifo_count}), 32'd0);
    rst = 1'b1;
    repeat (HALF) @(negedge clk);

    // single make code with latency check
    send_frame(8'h1C, 1'b0, 1'b1, -1, 1'b1, 11);
    chk("one_count", 32'(fifo_count), 32'd1);
    pop_chk("one_evt", 8'h1C, 1'b0, 1'b0);
    chk("one_noerr", 32'(err_cnt), 32'd0);

    // prefixed sequences
    good(8'hE0); good(8'hF0); good(8'h75);
    chk("e0f0_count", 32'(fifo_count), 32'd1);
    pop_chk("e0f0_evt", 8'h75, 1'b1, 1'b1);
    good(8'hF0); good(8'h1C);
    pop_chk("f0_evt", 8'h1C, 1'b0, 1'b1);

    // parity and stop errors
    send_frame(8'h1C, 1'b1, 1'b1, -1, 1'b0, 11);
    chk("par_err", 32'({err_cnt[7:0], last_err}), 32'({8'd1, 2'b01}));
    chk("par_noevt", 32'(fifo_count), 32'd0);
    send_frame(8'h1C, 1'b0, 1'b0, -1, 1'b0, 11);
    chk("stop_err", 32'({err_cnt[7:0], last_err}), 32'({8'd2, 2'b10}));
    chk("both_bad", 32'(fifo_count), 32'd0);
    // an error between a prefix and its code clears the prefix
    good(8'hE0);
    send_frame(8'h1C, 1'b1, 1'b0, -1, 1'b0, 11);
    chk("both_bad_par", 32'({err_cnt[7:0], last_err}), 32'({8'd3, 2'b01}));
    good(8'h1C);
    pop_chk("err_clr_pend", 8'h1C, 1'b0, 1'b0);

    // timeout after a partial frame
    send_frame(8'h5A, 1'b0, 1'b1, -1, 1'b0, 5);
    chk("tmo_early", 32'(err_cnt), 32'd3);
    repeat (TMO) @(negedge clk);
    chk("tmo_err", 32'({err_cnt[7:0], last_err}), 32'({8'd4, 2'b11}));
    good(8'h1C);
    pop_chk("tmo_recover", 8'h1C, 1'b0, 1'b0);

    // fill, overflow, drain in order
    for (int i = 0; i < 9; i++) good(8'h10 + 8'(i));
    chk("full_count", 32'(fifo_count), 32'd8);
    chk("ovf_once", 32'(ovf_cnt), 32'd1);
    for (int i = 0; i < 8; i++) pop_chk($sformatf("drain%0d", i), 8'h10 + 8'(i), 1'b0, 1'b0);
    chk("empty_outs", 32'({key_valid, key_code, key_ext, key_release, fifo_count}), 32'd0);

    // short ps2_clk glitch inside a frame must not add a bit
    send_frame(8'h33, 1'b0, 1'b1, 3, 1'b0, 11);
    pop_chk("glitch_evt", 8'h33, 1'b0, 1'b0);
    chk("glitch_noerr", 32'(err_cnt), 32'd4);

    // reset mid-frame with an event queued and err_code held nonzero
    good(8'h24);
    send_frame(8'h24, 1'b0, 1'b0, -1, 1'b0, 11);
    chk("pre_rst_state", 32'({fifo_count, err_code}), 32'({4'd1, 2'b10}));
    send_frame(8'h4D, 1'b0, 1'b1, -1, 1'b0, 4);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_outs", 32'({key_valid, key_code, key_ext, key_release, frame_err, err_code,
                            overflow, fifo_count}), 32'd0);
    rst = 1'b1;
    repeat (HALF) @(negedge clk);
    good(8'h2B);
    pop_chk("post_rst_evt", 8'h2B, 1'b0, 1'b0);
    chk("post_rst_err", 32'(err_cnt), 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog: got no finish, want finish within 200000 cycles");
    $fatal(1, "watchdog");
  end

endmodule
